// File: rtl/sliding_window_floating_point_if.sv
// Pixel-in / window-out bus of the sliding window generator.
// master drives the raster pixel stream; slave is the window generator.
interface sliding_window_floating_point_if #(
  parameter int EXP_WIDTH     = 8,
  parameter int FRAC_WIDTH    = 23,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3
);
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic [FP_WIDTH_REG-1:0]                                     data_i;
  logic [15:0]                                                 col_i;
  logic [15:0]                                                 row_i;
  logic                                                        valid_i;
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
  logic [15:0]                                                 col_o;
  logic [15:0]                                                 row_o;
  logic                                                        valid_o;

  modport master (
    output data_i, col_i, row_i, valid_i,
    input  window_o, col_o, row_o, valid_o
  );

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/sliding_window_floating_point.sv
// Raster-scan sliding window over floating-point pixels, 1-cycle latency, no backpressure.
// Define SLIDING_WINDOW_SUBNORMAL_FLUSH_EN to flush subnormal inputs to signed zero.
module sliding_window_floating_point #(
  parameter int EXP_WIDTH     = 8,
  parameter int FRAC_WIDTH    = 23,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640
) (
  input logic                             clk_i,
  input logic                             rst_i,
  sliding_window_floating_point_if.slave  sw
);
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int LB_ROWS      = WINDOW_HEIGHT - 1;
  localparam int ADDR_W       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [15:0] COL_OFS  = 16'((WINDOW_WIDTH - 1) / 2);
  localparam logic [15:0] ROW_OFS  = 16'((WINDOW_HEIGHT - 1) / 2);
  localparam logic [31:0] IMG_W    = 32'(IMAGE_WIDTH);
  localparam logic [31:0] MIN_COL  = 32'(WINDOW_WIDTH - 1);
  localparam logic [31:0] MIN_ROW  = 32'(WINDOW_HEIGHT - 1);

  logic [FP_WIDTH_REG-1:0] r_linebuf [LB_ROWS][IMAGE_WIDTH];
  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] r_window;
  logic [15:0]             r_col;
  logic [15:0]             r_row;
  logic                    r_valid;

  logic                    w_accept;
  logic                    w_win_vld;
  logic [ADDR_W-1:0]       w_addr;
  logic [FP_WIDTH_REG-1:0] w_pix;

  assign w_accept  = sw.valid_i && ({16'd0, sw.col_i} < IMG_W);
  assign w_win_vld = w_accept && ({16'd0, sw.row_i} >= MIN_ROW) && ({16'd0, sw.col_i} >= MIN_COL);
  assign w_addr    = sw.col_i[ADDR_W-1:0];

`ifdef SLIDING_WINDOW_SUBNORMAL_FLUSH_EN
  assign w_pix = (sw.data_i[FP_WIDTH_REG-2 -: EXP_WIDTH] == '0)
               ? {sw.data_i[FP_WIDTH_REG-1], {(FP_WIDTH_REG-1){1'b0}}}
               : sw.data_i;
`else
  assign w_pix = sw.data_i;
`endif

  // Line buffers carry no reset; stale contents are masked by the row/column gating of valid.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int r = 0; r < LB_ROWS - 1; r++) begin
        r_linebuf[r][w_addr] <= r_linebuf[r+1][w_addr];
      end
      r_linebuf[LB_ROWS-1][w_addr] <= w_pix;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_window <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_win_vld;
      if (w_accept) begin
        for (int r = 0; r < WINDOW_HEIGHT; r++) begin
          for (int c = 0; c < WINDOW_WIDTH - 1; c++) begin
            r_window[r][c] <= r_window[r][c+1];
          end
        end
        for (int r = 0; r < LB_ROWS; r++) begin
          r_window[r][WINDOW_WIDTH-1] <= r_linebuf[r][w_addr];
        end
        r_window[WINDOW_HEIGHT-1][WINDOW_WIDTH-1] <= w_pix;
        r_col <= sw.col_i - COL_OFS;
        r_row <= sw.row_i - ROW_OFS;
      end
    end
  end

  assign sw.window_o = r_window;
  assign sw.col_o    = r_col;
  assign sw.row_o    = r_row;
  assign sw.valid_o  = r_valid;
endmodule

// File: tb/tb_sliding_window_floating_point.sv
// Bench for sliding_window_floating_point: 3x3 window, 8-pixel lines, image-level reference model.
module tb_sliding_window_floating_point;
  typedef logic [2:0][2:0][31:0] win_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;
  logic [31:0] img [0:7][0:7];
  logic [15:0] exp_col = '0;
  logic [15:0] exp_row = '0;

  sliding_window_floating_point_if #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .WINDOW_WIDTH(3), .WINDOW_HEIGHT(3)
  ) sw ();

  sliding_window_floating_point #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .WINDOW_WIDTH(3), .WINDOW_HEIGHT(3), .IMAGE_WIDTH(8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sw   (sw)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] flush(input logic [31:0] d);
`ifdef SLIDING_WINDOW_SUBNORMAL_FLUSH_EN
    return (d[30:23] == 8'd0) ? {d[31], 31'd0} : d;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one input cycle (called at a negedge) and check the outputs one cycle later.
  task automatic step(input logic v, input logic [31:0] d, input logic [15:0] c, input logic [15:0] r);
    logic acc, ev;
    win_t ew;
    sw.valid_i = v;
    sw.data_i  = d;
    sw.col_i   = c;
    sw.row_i   = r;
    acc = v && (c < 16'd8);
    ev  = acc && (r >= 16'd2) && (c >= 16'd2);
    if (acc) begin
      img[r][c] = flush(d);
      exp_col   = c - 16'd1;
      exp_row   = r - 16'd1;
    end
    @(negedge clk_i);
    chk("valid_o", {287'd0, sw.valid_o}, {287'd0, ev});
    chk("col_o", {272'd0, sw.col_o}, {272'd0, exp_col});
    chk("row_o", {272'd0, sw.row_o}, {272'd0, exp_row});
    if (ev) begin
      vcount++;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          ew[i][j] = img[int'(r) - 2 + i][int'(c) - 2 + j];
      chk("window_o", sw.window_o, ew);
    end
  endtask

  task automatic idle();
    step(1'b0, $urandom, 16'($urandom), 16'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win"}, sw.window_o, '0);
    chk({tag, "_col"}, {272'd0, sw.col_o}, '0);
    chk({tag, "_row"}, {272'd0, sw.row_o}, '0);
    chk({tag, "_vld"}, {287'd0, sw.valid_o}, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sw.valid_i = 1'b0;
    sw.data_i  = '0;
    sw.col_i   = '0;
    sw.row_i   = '0;
    #1;
    chk_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Continuous frame with pixel = row*16+col
    vcount = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 32'(r * 16 + c), 16'(c), 16'(r));
        if (r == 2 && c == 2) begin
          chk("first_w00", {256'd0, sw.window_o[0][0]}, {256'd0, flush(32'h00)});
          chk("first_w22", {256'd0, sw.window_o[2][2]}, {256'd0, flush(32'h22)});
        end
        if (r == 3 && c == 2) begin
          chk("row3_w00", {256'd0, sw.window_o[0][0]}, {256'd0, flush(32'h10)});
          chk("row3_w22", {256'd0, sw.window_o[2][2]}, {256'd0, flush(32'h32)});
        end
      end
    end
    chk("count_cont", {256'd0, 32'(vcount)}, {256'd0, 32'd36});

    // Same frame with valid_i alternating
    vcount = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b1, 32'(r * 16 + c), 16'(c), 16'(r));
        idle();
      end
    end
    chk("count_alt", {256'd0, 32'(vcount)}, {256'd0, 32'd36});

    // Out-of-range columns injected between pixels
    vcount = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 3) == 0)
          step(1'b1, $urandom, 16'(8 + $urandom_range(0, 65527)), 16'(r));
        if (r == 5 && c == 4)
          step(1'b1, $urandom, 16'd8, 16'(r));
        step(1'b1, 32'(r * 16 + c), 16'(c), 16'(r));
      end
    end
    chk("count_drop", {256'd0, 32'(vcount)}, {256'd0, 32'd36});

    // Asynchronous reset mid-frame at (row4,col3), then a fresh frame
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (!(r > 4 || (r == 4 && c > 3)))
          step(1'b1, 32'h4000_0000 | 32'(r * 16 + c), 16'(c), 16'(r));
      end
    end
    #2 rst_i = 1'b1;
    #1 chk_zero("midrst");
    sw.valid_i = 1'b0;
    @(negedge clk_i);
    rst_i   = 1'b0;
    exp_col = '0;
    exp_row = '0;
    vcount  = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        step(1'b1, 32'(r * 16 + c), 16'(c), 16'(r));
    chk("count_postrst", {256'd0, 32'(vcount)}, {256'd0, 32'd36});

    // Random frames: random data (some subnormal), gaps and drops
    for (int f = 0; f < 3; f++) begin
      vcount = 0;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          logic [31:0] d;
          d = $urandom;
          if ($urandom_range(0, 3) == 0) d = d & 32'h807F_FFFF;
          if ($urandom_range(0, 3) == 0) idle();
          if ($urandom_range(0, 5) == 0)
            step(1'b1, $urandom, 16'(8 + $urandom_range(0, 65527)), 16'(r));
          step(1'b1, d, 16'(c), 16'(r));
        end
      end
      chk("count_rand", {256'd0, 32'(vcount)}, {256'd0, 32'd36});
    end

    // Subnormal handling on the newest window row
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [31:0] d;
        d = 32'h4100_0000 | 32'(r * 16 + c);
        if (r == 2 && c == 0) d = 32'h8000_0005;
        if (r == 2 && c == 1) d = 32'h3F80_0000;
        if (r == 2 && c == 2) d = 32'h0000_0001;
        step(1'b1, d, 16'(c), 16'(r));
      end
    end
`ifdef SLIDING_WINDOW_SUBNORMAL_FLUSH_EN
    chk("sub_neg", {256'd0, sw.window_o[2][0]}, {256'd0, 32'h8000_0000});
    chk("sub_one", {256'd0, sw.window_o[2][1]}, {256'd0, 32'h3F80_0000});
    chk("sub_pos", {256'd0, sw.window_o[2][2]}, {256'd0, 32'h0000_0000});
`else
    chk("sub_neg", {256'd0, sw.window_o[2][0]}, {256'd0, 32'h8000_0005});
    chk("sub_one", {256'd0, sw.window_o[2][1]}, {256'd0, 32'h3F80_0000});
    chk("sub_pos", {256'd0, sw.window_o[2][2]}, {256'd0, 32'h0000_0001});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sliding_window_floating_point.md
SLIDING_WINDOW_FLOATING_POINT -- requirements
Module: sliding_window_floating_point

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8: exponent width of pixel format.
REQ-002 SHALL have parameter FRAC_WIDTH, default 23: fraction width; pixel width FP_WIDTH_REG = 1+EXP_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have parameter WINDOW_WIDTH, default 3: window columns, >=1.
REQ-004 SHALL have parameter WINDOW_HEIGHT, default 3: window rows, >=2.
REQ-005 SHALL have parameter IMAGE_WIDTH, default 640: maximum line length, line buffer depth.
REQ-006 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port data_i  input  FP_WIDTH_REG  raster pixel.
REQ-009 SHALL have port col_i  input  16  pixel column.
REQ-010 SHALL have port row_i  input  16  pixel row.
REQ-011 SHALL have port valid_i  input  1  pixel qualifier; no backpressure.
REQ-012 SHALL have port window_o  output  [WINDOW_HEIGHT][WINDOW_WIDTH] x FP_WIDTH_REG  window; [0][0] oldest row/leftmost column, [H-1][W-1] newest pixel.
REQ-013 SHALL have port col_o  output  16  window centre column.
REQ-014 SHALL have port row_o  output  16  window centre row.
REQ-015 SHALL have port valid_o  output  1  window qualifier; drives a convolution engine's window_i/col_i/row_i/valid_i directly.

Function
REQ-016 SHALL hold WINDOW_HEIGHT-1 line buffers of IMAGE_WIDTH entries, addressed by col_i, read-before-write in the same cycle.
REQ-017 On accepted pixel (valid_i=1, col_i<IMAGE_WIDTH): window rows shift left one column; window[r][W-1] <= linebuf[r][col_i] for r<H-1; window[H-1][W-1] <= data_i.
REQ-018 Same cycle: linebuf[r][col_i] <= linebuf[r+1][col_i] for r<H-2; linebuf[H-2][col_i] <= data_i.
REQ-019 Latency exactly 1 cycle: valid_o, window_o, col_o, row_o registered the cycle after acceptance.
REQ-020 valid_o=1 only for accepted pixels with row_i>=WINDOW_HEIGHT-1 and col_i>=WINDOW_WIDTH-1; otherwise 0 that cycle.
REQ-021 col_o = col_i-(WINDOW_WIDTH-1)/2, row_o = row_i-(WINDOW_HEIGHT-1)/2, integer division, 16-bit, captured on acceptance.
REQ-022 valid_i=0: window, line buffers, col_o, row_o hold; valid_o=0.
REQ-023 col_i>=IMAGE_WIDTH with valid_i=1: pixel dropped, no state change, valid_o=0.
REQ-024 Line start: stale columns from previous line SHALL NOT reach a valid window (guaranteed by REQ-020 gating, no explicit flush).
REQ-025 Frame start (row_i<WINDOW_HEIGHT-1): line buffers filled, valid_o stays 0; no frame-end signal required.
REQ-026 Pixel values SHALL pass bit-exact (no arithmetic) except per REQ-031.

Reset
REQ-027 rst_i high: window_o all zero, col_o=0, row_o=0, valid_o=0 immediately, independent of clk_i.
REQ-028 Line buffers need not reset; reset mid-frame SHALL yield no valid_o until a new frame reaches row WINDOW_HEIGHT-1, col WINDOW_WIDTH-1.

Configuration
REQ-029 Macro SLIDING_WINDOW_SUBNORMAL_FLUSH_EN selects subnormal flushing on input.
REQ-030 Without macro: data_i stored unchanged.
REQ-031 With macro: data_i with exponent field zero stored as sign bit followed by all zeros (signed zero) before window and line buffer write; latency unchanged.

Verification (EXP_WIDTH=8, FRAC_WIDTH=23, 3x3, IMAGE_WIDTH=8, data_i = row*16+col)
REQ-032 8x8 frame, continuous valid_i -> first valid_o one cycle after (row2,col2): window_o[0][0]=0x00, [2][2]=0x22, col_o=1, row_o=1; 36 valid_o total.
REQ-033 Same frame, valid_i alternating 1/0 -> identical window sequence, 36 valid_o, valid_o never high in cycle after valid_i=0.
REQ-034 Row 3 inputs col0, col1 -> valid_o=0; col2 -> valid_o=1, window_o[0][0]=0x10, [2][2]=0x32.
REQ-035 rst_i asserted mid-cycle at (row4,col3) -> outputs zero before next clk edge; new frame gives no valid_o before (row2,col2).
REQ-036 col_i=8, valid_i=1 -> valid_o=0, next accepted pixel's window identical to no-drop case.
REQ-037 Macro defined: data_i 0x00000001 -> 0x00000000, 0x80000005 -> 0x80000000, 0x3F800000 unchanged; undefined: all unchanged.
